// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with in-order request issue and decode queue
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        panic,
  output logic        halted
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          running;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redir_target;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] stale;
  logic [CW-1:0] resp_dec;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   q_data [QUEUE_DEPTH];
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic          has_room;
  logic          req_fire;
  logic          redir;
  logic          flush;
  logic          enq;
  logic          deq;

  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (panic) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    halted  = (state == HALT);
  end

  // Issue depends only on registered counts so a response slot is always reserved.
  assign has_room       = ({1'b0, inflight} + {1'b0, count}) < {1'b0, DEPTH_C};
  assign imem_req_valid = reset & running & ~panic & ~redirect_valid & has_room;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign redir_target = redirect_pc & ~32'h3;
  assign redir        = running & ~panic & redirect_valid;
  assign flush        = redir | (running & panic);
  assign resp_dec     = CW'(imem_resp_valid && (inflight != '0));
  assign enq          = imem_resp_valid & running & ~panic & ~redirect_valid & (stale == '0);

  assign instr_valid = running & (count != '0);
  assign deq         = instr_valid & decode_ready;
  assign instruction = instr_valid ? q_data[head] : 32'h0;
  assign instr_pc    = instr_valid ? q_pc[head]   : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      stale    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - resp_dec;
      // Everything still outstanding after this cycle's response belongs to the old stream.
      if (redir)
        stale <= inflight - resp_dec;
      else if (imem_resp_valid && (stale != '0))
        stale <= stale - CW'(1);
      if (flush) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        count <= count + CW'(enq) - CW'(deq);
        if (enq) tail <= tail + AW'(1);
        if (deq) head <= head + AW'(1);
      end
      if (redir)         pc <= redir_target;
      else if (req_fire) pc <= pc + 32'd4;
      if (redir)    resp_pc <= redir_target;
      else if (enq) resp_pc <= resp_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_data[tail] <= imem_resp_data;
      q_pc[tail]   <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (enq) assert (count < DEPTH_C);
      assert (stale <= inflight);
    end
  end

endmodule
